// File: rtl/svm_kernel_sched.sv
// Sequencer for one SVM dot-product kernel: streams test/support vector pairs
// into the kernel beat interface and accumulates bias + sum(alpha * kernel).
module svm_kernel_sched #(
  parameter int DIM = 4,
  parameter int NSV = 2,
  parameter int TAW = (DIM > 1) ? $clog2(DIM) : 1,
  parameter int SAW = (NSV * DIM > 1) ? $clog2(NSV * DIM) : 1,
  parameter int AAW = (NSV > 1) ? $clog2(NSV) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic signed [31:0]  bias_i,
  output logic                busy_o,
  output logic                done_o,
  output logic signed [63:0]  decision_o,
  output logic                class_out_o,
  output logic [TAW-1:0]      test_addr_o,
  input  logic signed [31:0]  test_data_i,
  output logic [SAW-1:0]      sv_addr_o,
  input  logic signed [31:0]  sv_data_i,
  output logic [AAW-1:0]      alpha_addr_o,
  input  logic signed [31:0]  alpha_data_i,
  output logic signed [31:0]  k_test_o,
  output logic signed [31:0]  k_support_o,
  output logic                k_start_o,
  output logic                k_end_o,
  output logic                k_valid_o,
  input  logic signed [31:0]  k_out_i,
  input  logic                k_out_valid_i,
  output logic [2:0]          state_o
);

  // Beat interface: k_valid_o qualifies a beat; the kernel has no ready and
  // must accept every beat. k_out_valid_i is a one-cycle result strobe.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_TERM   = 3'd2,
    S_WAIT_K = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [TAW-1:0]     feat_q, feat_d;
  logic [AAW-1:0]     sv_q, sv_d;
  logic signed [63:0] acc_q, acc_d;
  logic signed [31:0] alpha_q, alpha_d;
  logic signed [63:0] decision_q, decision_d;
  logic               class_q, class_d;
  logic               done_q, done_d;
  logic               k_valid_q, k_start_q, k_end_q;
  logic               iss_valid, iss_start, iss_end;
  logic               feat_last, sv_last;
  logic signed [63:0] alpha_ext, kout_ext, prod;

  assign feat_last = (feat_q == TAW'(DIM - 1));
  assign sv_last   = (sv_q == AAW'(NSV - 1));
  assign alpha_ext = {{32{alpha_q[31]}}, alpha_q};
  assign kout_ext  = {{32{k_out_i[31]}}, k_out_i};
  assign prod      = alpha_ext * kout_ext;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_STREAM;
      S_STREAM: if (feat_last) state_d = S_TERM;
      S_TERM:   state_d = S_WAIT_K;
      S_WAIT_K: if (k_out_valid_i) state_d = sv_last ? S_DONE : S_STREAM;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != S_IDLE);
    iss_valid = (state_q == S_STREAM) || (state_q == S_TERM);
    iss_start = (state_q == S_STREAM) && (feat_q == '0);
    iss_end   = (state_q == S_TERM);
  end

  // Result registers load on the final accumulate so they are valid in DONE.
  always_comb begin
    feat_d     = feat_q;
    sv_d       = sv_q;
    acc_d      = acc_q;
    alpha_d    = alpha_q;
    decision_d = decision_q;
    class_d    = class_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        acc_d  = {{32{bias_i[31]}}, bias_i};
        sv_d   = '0;
        feat_d = '0;
      end
      S_STREAM: if (!feat_last) feat_d = feat_q + TAW'(1);
      S_TERM: begin
        feat_d  = '0;
        alpha_d = alpha_data_i;
      end
      S_WAIT_K: if (k_out_valid_i) begin
        acc_d = acc_q + prod;
        if (sv_last) begin
          done_d     = 1'b1;
          decision_d = acc_d;
          class_d    = ~acc_d[63];
        end else begin
          sv_d = sv_q + AAW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      feat_q     <= '0;
      sv_q       <= '0;
      acc_q      <= '0;
      alpha_q    <= '0;
      decision_q <= '0;
      class_q    <= 1'b1;
      done_q     <= 1'b0;
      k_valid_q  <= 1'b0;
      k_start_q  <= 1'b0;
      k_end_q    <= 1'b0;
    end else begin
      feat_q     <= feat_d;
      sv_q       <= sv_d;
      acc_q      <= acc_d;
      alpha_q    <= alpha_d;
      decision_q <= decision_d;
      class_q    <= class_d;
      done_q     <= done_d;
      k_valid_q  <= iss_valid;
      k_start_q  <= iss_start;
      k_end_q    <= iss_end;
    end
  end

  // Flags are delayed one cycle so the operands come straight from read data.
  assign k_valid_o    = k_valid_q;
  assign k_start_o    = k_start_q;
  assign k_end_o      = k_end_q;
  assign k_test_o     = (k_valid_q && !k_end_q) ? test_data_i : 32'sd0;
  assign k_support_o  = (k_valid_q && !k_end_q) ? sv_data_i : 32'sd0;
  assign test_addr_o  = feat_q;
  assign sv_addr_o    = SAW'(32'(sv_q) * 32'(DIM) + 32'(feat_q));
  assign alpha_addr_o = sv_q;
  assign done_o       = done_q;
  assign decision_o   = decision_q;
  assign class_out_o  = class_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_svm_kernel_sched.sv
// Bench for svm_kernel_sched: two instances (DIM=4/NSV=2 and DIM=1/NSV=3)
// with memory and kernel models, an arithmetic reference and a cycle compare.
module tb_svm_kernel_sched;

  localparam int LAT_A = 2 * (4 + 3) + 1;
  localparam int LAT_B = 3 * (1 + 3) + 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   check_en = 0;

  // instance A signals
  logic               start_a, busy_a, done_a, class_a;
  logic signed [31:0] bias_a;
  logic signed [63:0] decision_a;
  logic [1:0]         test_addr_a;
  logic [2:0]         sv_addr_a;
  logic [0:0]         alpha_addr_a;
  logic signed [31:0] test_data_a = 0, sv_data_a = 0, alpha_data_a = 0;
  logic signed [31:0] k_test_a, k_support_a, k_out_a;
  logic               k_start_a, k_end_a, k_valid_a, k_out_valid_a;
  logic [2:0]         state_a;

  // instance B signals
  logic               start_b, busy_b, done_b, class_b;
  logic signed [31:0] bias_b;
  logic signed [63:0] decision_b;
  logic [0:0]         test_addr_b;
  logic [1:0]         sv_addr_b;
  logic [1:0]         alpha_addr_b;
  logic signed [31:0] test_data_b = 0, sv_data_b = 0, alpha_data_b = 0;
  logic signed [31:0] k_test_b, k_support_b, k_out_b;
  logic               k_start_b, k_end_b, k_valid_b, k_out_valid_b;
  logic [2:0]         state_b;

  int test_mem_a[4], sv_mem_a[8], alpha_mem_a[2];
  int test_mem_b[2], sv_mem_b[4], alpha_mem_b[4];

  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  int kres_log_a[$];
  int kres_log_b[$];
  int ksc_a = 0, ksc_b = 0, kec_b = 0;
  int a_start = -1, b_start = -1;
  int spur_at_a = -100;

  svm_kernel_sched #(.DIM(4), .NSV(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .bias_i(bias_a),
    .busy_o(busy_a), .done_o(done_a), .decision_o(decision_a), .class_out_o(class_a),
    .test_addr_o(test_addr_a), .test_data_i(test_data_a),
    .sv_addr_o(sv_addr_a), .sv_data_i(sv_data_a),
    .alpha_addr_o(alpha_addr_a), .alpha_data_i(alpha_data_a),
    .k_test_o(k_test_a), .k_support_o(k_support_a),
    .k_start_o(k_start_a), .k_end_o(k_end_a), .k_valid_o(k_valid_a),
    .k_out_i(k_out_a), .k_out_valid_i(k_out_valid_a), .state_o(state_a)
  );

  svm_kernel_sched #(.DIM(1), .NSV(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .bias_i(bias_b),
    .busy_o(busy_b), .done_o(done_b), .decision_o(decision_b), .class_out_o(class_b),
    .test_addr_o(test_addr_b), .test_data_i(test_data_b),
    .sv_addr_o(sv_addr_b), .sv_data_i(sv_data_b),
    .alpha_addr_o(alpha_addr_b), .alpha_data_i(alpha_data_b),
    .k_test_o(k_test_b), .k_support_o(k_support_b),
    .k_start_o(k_start_b), .k_end_o(k_end_b), .k_valid_o(k_valid_b),
    .k_out_i(k_out_b), .k_out_valid_i(k_out_valid_b), .state_o(state_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // synchronous-read memories
  always @(posedge clk) begin
    test_data_a  <= test_mem_a[test_addr_a];
    sv_data_a    <= sv_mem_a[sv_addr_a];
    alpha_data_a <= alpha_mem_a[alpha_addr_a];
    test_data_b  <= test_mem_b[test_addr_b];
    sv_data_b    <= sv_mem_b[sv_addr_b];
    alpha_data_b <= alpha_mem_b[alpha_addr_b];
  end

  // kernel models: dot product over beats, result one cycle after the end beat
  int  kacc_a = 0, kacc_b = 0;
  bit  kpend_a = 0, kpend_b = 0;
  always @(negedge clk) begin
    if (kpend_a) begin
      k_out_valid_a = 1'b1; k_out_a = kacc_a; kres_log_a.push_back(kacc_a);
    end else if (cyc == spur_at_a) begin
      k_out_valid_a = 1'b1; k_out_a = 1000;
    end else begin
      k_out_valid_a = 1'b0; k_out_a = 0;
    end
    kpend_a = 0;
    if (k_valid_a === 1'b1) begin
      if (k_end_a) kpend_a = 1;
      else if (k_start_a) begin kacc_a = k_test_a * k_support_a; ksc_a++; end
      else kacc_a += k_test_a * k_support_a;
    end
    if (kpend_b) begin
      k_out_valid_b = 1'b1; k_out_b = kacc_b; kres_log_b.push_back(kacc_b);
    end else begin
      k_out_valid_b = 1'b0; k_out_b = 0;
    end
    kpend_b = 0;
    if (k_valid_b === 1'b1) begin
      if (k_end_b) begin kpend_b = 1; kec_b++; end
      else if (k_start_b) begin kacc_b = k_test_b * k_support_b; ksc_b++; end
      else kacc_b += k_test_b * k_support_b;
    end
  end

  task automatic chk(input string nm, input logic signed [64:0] act, input logic signed [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: bias + sum over support vectors of alpha * dot(test, sv)
  function automatic logic [64:0] model_a(input int b);
    longint s = b;
    for (int v = 0; v < 2; v++) begin
      longint dot = 0;
      for (int f = 0; f < 4; f++) dot += longint'(test_mem_a[f]) * longint'(sv_mem_a[v*4+f]);
      s += longint'(alpha_mem_a[v]) * dot;
    end
    return {s >= 0, 64'(s)};
  endfunction

  function automatic logic [64:0] model_b(input int b);
    longint s = b;
    for (int v = 0; v < 3; v++)
      s += longint'(alpha_mem_b[v]) * longint'(test_mem_b[0]) * longint'(sv_mem_b[v]);
    return {s >= 0, 64'(s)};
  endfunction

  // compare process
  logic [64:0] hold_a = {1'b1, 64'd0}, hold_b = {1'b1, 64'd0};
  logic [64:0] e;
  bit a_run = 0, b_run = 0, rst_seen = 0;
  int a_last = -1, b_last = -1, a_ks0 = 0, b_ks0 = 0, b_ke0 = 0, rel;
  always @(negedge clk) if (check_en) begin
    if (rst_seen) begin
      if (a_run && exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (b_run && exp_q1.size() > 0) void'(exp_q1.pop_front());
      a_run = 0; b_run = 0;
      hold_a = {1'b1, 64'd0}; hold_b = {1'b1, 64'd0};
    end
    rst_seen = !rst;
    if (a_start != a_last) begin a_last = a_start; a_run = 1; a_ks0 = ksc_a; end
    if (b_start != b_last) begin b_last = b_start; b_run = 1; b_ks0 = ksc_b; b_ke0 = kec_b; end

    if (a_run) begin
      rel = cyc - a_start;
      chk("a_busy", busy_a, (rel >= 1 && rel <= LAT_A));
      chk("a_done", done_a, (rel == LAT_A));
      if (rel >= LAT_A) begin
        chk("a_exp_avail", exp_q0.size() > 0, 1);
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          chk("a_decision", decision_a, $signed(e[63:0]));
          chk("a_class", class_a, e[64]);
          hold_a = e;
        end
        chk("a_kstart_beats", ksc_a - a_ks0, 2);
        a_run = 0;
      end
    end else begin
      chk("a_idle_busy", busy_a, 0);
      chk("a_idle_done", done_a, 0);
      chk("a_hold_decision", decision_a, $signed(hold_a[63:0]));
      chk("a_hold_class", class_a, hold_a[64]);
    end

    if (b_run) begin
      rel = cyc - b_start;
      chk("b_busy", busy_b, (rel >= 1 && rel <= LAT_B));
      chk("b_done", done_b, (rel == LAT_B));
      if (rel >= LAT_B) begin
        chk("b_exp_avail", exp_q1.size() > 0, 1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          chk("b_decision", decision_b, $signed(e[63:0]));
          chk("b_class", class_b, e[64]);
          hold_b = e;
        end
        chk("b_kstart_beats", ksc_b - b_ks0, 3);
        chk("b_kend_beats", kec_b - b_ke0, 3);
        b_run = 0;
      end
    end else begin
      chk("b_idle_busy", busy_b, 0);
      chk("b_hold_decision", decision_b, $signed(hold_b[63:0]));
      chk("b_hold_class", class_b, hold_b[64]);
    end

    if (!k_valid_a) chk("a_quiet_beat", {k_start_a, k_end_a, k_test_a != 0, k_support_a != 0}, 0);
    else if (k_end_a) chk("a_term_beat", {k_start_a, k_test_a != 0, k_support_a != 0}, 0);
    if (!k_valid_b) chk("b_quiet_beat", {k_start_b, k_end_b, k_test_b != 0, k_support_b != 0}, 0);
    else if (k_end_b) chk("b_term_beat", {k_start_b, k_test_b != 0, k_support_b != 0}, 0);
    else chk("b_data_beat_start", k_start_b, 1);
  end

  // driver tasks
  task automatic run_a(input int b);
    @(posedge clk); #1;
    bias_a = b; start_a = 1'b1; a_start = cyc;
    exp_q0.push_back(model_a(b));
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic run_b(input int b);
    @(posedge clk); #1;
    bias_b = b; start_b = 1'b1; b_start = cyc;
    exp_q1.push_back(model_b(b));
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin ok = 1; break; end
    end
    chk({nm, "_done_seen"}, ok, 1);
  endtask

  task automatic wait_done_b(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) begin ok = 1; break; end
    end
    chk({nm, "_done_seen"}, ok, 1);
  endtask

  task automatic wait_rel_a(input int r);
    while (cyc < a_start + r) begin @(posedge clk); #1; end
  endtask

  int kb;
  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; bias_a = 0; bias_b = 0;
    test_mem_a = '{1, 2, 3, 4};
    sv_mem_a   = '{1, 1, 1, 1, 2, 0, 0, 1};
    alpha_mem_a = '{3, -2};
    test_mem_b = '{-7, 0};
    sv_mem_b   = '{1, 2, 3, 0};
    alpha_mem_b = '{1, 1, 1, 0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_en = 1;

    // T1: basic run
    kb = kres_log_a.size();
    run_a(5);
    wait_done_a("t1");
    chk("t1_done_cycle", cyc - a_start, 15);
    chk("t1_decision", decision_a, 23);
    chk("t1_class", class_a, 1);
    chk("t1_kres_count", kres_log_a.size() - kb, 2);
    if (kres_log_a.size() >= kb + 2) begin
      chk("t1_kernel0", kres_log_a[kb], 10);
      chk("t1_kernel1", kres_log_a[kb+1], 6);
    end
    repeat (2) @(posedge clk);

    // T2: negative decision, held after done
    alpha_mem_a = '{-3, -2};
    run_a(0);
    wait_done_a("t2");
    chk("t2_decision", decision_a, -42);
    chk("t2_class", class_a, 0);
    repeat (4) @(negedge clk);
    chk("t2_held_decision", decision_a, -42);
    chk("t2_held_class", class_a, 0);

    // T3: start while busy is ignored
    alpha_mem_a = '{3, -2};
    run_a(5);
    wait_rel_a(4);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a("t3");
    chk("t3_done_cycle", cyc - a_start, 15);
    chk("t3_decision", decision_a, 23);
    repeat (2) @(posedge clk);

    // T4: reset mid-run, then a clean run
    run_a(5);
    wait_rel_a(7);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t4_rst_busy", busy_a, 0);
    chk("t4_rst_done", done_a, 0);
    chk("t4_rst_kflags", {k_valid_a, k_start_a, k_end_a}, 0);
    chk("t4_rst_ktest", k_test_a, 0);
    chk("t4_rst_ksupport", k_support_a, 0);
    chk("t4_rst_decision", decision_a, 0);
    chk("t4_rst_class", class_a, 1);
    chk("t4_rst_addrs", {test_addr_a, sv_addr_a, alpha_addr_a}, 0);
    run_a(5);
    wait_done_a("t4");
    chk("t4_done_cycle", cyc - a_start, 15);
    chk("t4_decision", decision_a, 23);
    repeat (2) @(posedge clk);

    // T5: spurious kernel strobe during STREAM
    run_a(5);
    spur_at_a = a_start + 2;
    wait_done_a("t5");
    chk("t5_decision", decision_a, 23);
    chk("t5_class", class_a, 1);
    repeat (2) @(posedge clk);

    // T6: DIM=1, NSV=3
    kb = kres_log_b.size();
    run_b(0);
    wait_done_b("t6");
    chk("t6_done_cycle", cyc - b_start, 13);
    chk("t6_decision", decision_b, -42);
    chk("t6_class", class_b, 0);
    chk("t6_kres_count", kres_log_b.size() - kb, 3);
    if (kres_log_b.size() >= kb + 3) begin
      chk("t6_kernel0", kres_log_b[kb], -7);
      chk("t6_kernel1", kres_log_b[kb+1], -14);
      chk("t6_kernel2", kres_log_b[kb+2], -21);
    end
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_kernel_sched.md
Name: svm_kernel_sched

Overview:
Sequencer for one dot-product kernel in the SVM classifier. On start it streams the test vector against each support vector in turn from synchronous-read memories into the kernel's start/end/valid beat interface. It weights each kernel result by that support vector's alpha and accumulates the results with the bias. It then reports the decision value and class. It sits between the vector/alpha memories and a single kernel instance.

Parameters:
DIM, 4, features per vector (>=1)
NSV, 2, number of support vectors (>=1)
TAW, $clog2(DIM) (min 1), test-memory address width
SAW, $clog2(NSV*DIM) (min 1), support-memory address width
AAW, $clog2(NSV) (min 1), alpha-memory address width

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous active-low reset
start  in  1  begin classification; sampled in IDLE only
bias  in  32 signed  added at start; sampled in the start cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when decision/class are valid
decision  out  64 signed  bias + sum(alpha*kernel); held until next start
class_out  out  1  1 when decision >= 0
test_addr  out  TAW  test-memory address; data returns next cycle
test_data  in  32 signed  test-memory read data
sv_addr  out  SAW  support-memory address = sv*DIM + feat
sv_data  in  32 signed  support-memory read data
alpha_addr  out  AAW  alpha-memory address = current sv
alpha_data  in  32 signed  alpha-memory read data (1-cycle latency)
k_test, k_support  out  32 signed  kernel operands
k_start, k_end, k_valid  out  1  kernel beat flags
k_out  in  32 signed  kernel result
k_out_valid  in  1  kernel result strobe

Behaviour:
- Reset (rst=0 at posedge): state IDLE; busy, done, k_valid, k_start, k_end = 0; k_test, k_support = 0; decision = 0; class_out = 1; sv and feat counters = 0; all addresses = 0.
- FSM states: IDLE, STREAM, TERM, WAIT_K, DONE.
- IDLE:
  - start=1 -> acc <= sign-extended bias; sv <= 0; feat <= 0; go to STREAM.
- STREAM, one cycle per feature:
  - test_addr = feat; sv_addr = sv*DIM + feat; alpha_addr = sv.
  - feat increments each cycle. After feat = DIM-1, go to TERM.
- TERM, one cycle:
  - Issues the terminator beat; feat <= 0.
  - Latches alpha_reg <= alpha_data (alpha_addr has been stable since the first STREAM cycle of this sv).
  - Go to WAIT_K.
- Beat pipeline: issue flags are registered one cycle so they line up with memory read data.
  - Beat driven in cycle t+1 for a STREAM cycle t: k_valid=1; k_start=1 only for feat=0; k_end=0; k_test=test_data; k_support=sv_data.
  - Beat for the TERM cycle: k_valid=1, k_end=1, k_start=0, k_test=k_support=0. The kernel does not accumulate the end beat's data, so the terminator beat carries zeros.
  - All other cycles: k_valid=k_start=k_end=0, operands 0.
- WAIT_K:
  - On k_out_valid=1: acc <= acc + alpha_reg*k_out (full 64-bit signed product, 64-bit wrap on overflow).
  - If sv = NSV-1 go to DONE, else sv++ and go to STREAM.
  - The kernel pulses k_out_valid 2 cycles after TERM, so each support vector takes exactly DIM+3 cycles. With no k_out_valid, WAIT_K holds indefinitely (no timeout).
- DONE, one cycle: decision <= acc; class_out <= ~acc[63]; done=1 is driven registered, so it is visible in the cycle after the final accumulate. Go to IDLE.
- Latency: start sampled at cycle 0 -> done high in cycle NSV*(DIM+3)+1; decision/class valid from that cycle.
- start while busy: ignored, no restart. start in the same cycle as the DONE->IDLE return is not sampled; it is accepted in the following IDLE cycle.
- k_out_valid outside WAIT_K is ignored and acc is unchanged.
- Reset mid-operation: immediate return to IDLE with reset values. The kernel is reset separately; the scheduler's next k_start beat restarts the kernel from any state.
- DIM=1: a single STREAM cycle whose beat has k_start=1; TERM behaviour is unchanged.

Test Plan:
- DIM=4, NSV=2, bias=5, test=[1,2,3,4], sv0=[1,1,1,1], sv1=[2,0,0,1], alpha=[3,-2], with a kernel model -> kernels 10 and 6; decision = 5+30-12 = 23; class_out=1; done exactly at cycle 15.
- Same vectors, alpha=[-3,-2], bias=0 -> decision = -42; class_out=0; decision and class held after done until the next start.
- start pulsed again at cycle 4 of a run -> ignored: no extra k_start beat, done at cycle 15, result 23.
- rst=0 at cycle 7, then start -> all outputs at reset values the next cycle; the second run completes with decision=23 at cycle 15 after its start.
- Spurious k_out_valid during STREAM with k_out=1000 -> ignored; decision remains 23.
- DIM=1, NSV=3, test=[-7], sv=[1,2,3], alpha=[1,1,1], bias=0 -> beats have k_start=1 and k_end=0, each followed by a terminator beat; decision = -42; class_out=0; done at cycle 13.
